// File: rtl/imem_loader.sv
// Instruction memory program loader: assembles a little-endian byte stream into
// 32-bit words, writes them to instruction memory and releases the core when done.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LEN_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             core_hold
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [LEN_W-1:0]   word_idx_q, word_idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_d;
    logic               mem_we_d, busy_d, done_d, error_d, core_hold_d;
    logic               len_ok, last_word;

    // A start is a real load only for 1..DEPTH_WORDS words
    assign len_ok    = (len_words != '0) && (len_words <= DEPTH_LEN);
    assign last_word = (word_idx_q == len_q - LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = len_ok ? ST_RECV : ST_DONE;
                end
            end
            ST_RECV: begin
                if (in_valid && (byte_idx_q == 2'd3)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = last_word ? ST_DONE : ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; the fourth byte bypasses the assembly register
    always_comb begin
        in_ready    = (state_q == ST_RECV);
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        len_d       = len_q;
        asm_d       = asm_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        done_d      = done;
        error_d     = error;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (len_words > DEPTH_LEN) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else if (len_words == '0) begin
                        done_d  = 1'b1;
                        error_d = 1'b0;
                    end else begin
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        len_d      = len_words;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_addr_d  = BASE_ADDR + (ADDR_W'(word_idx_q) << 2);
                        mem_wdata_d = asm_d;
                    end
                end
            end
            ST_WRITE: begin
                if (last_word) begin
                    done_d = 1'b1;
                end else begin
                    word_idx_d = word_idx_q + LEN_W'(1);
                    byte_idx_d = '0;
                end
            end
            default: ;
        endcase
        mem_we_d    = (state_d == ST_WRITE);
        busy_d      = (state_d == ST_RECV) || (state_d == ST_WRITE);
        core_hold_d = !((state_d == ST_DONE) && !error_d);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= '0;
            word_idx_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_hold  <= 1'b1;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            core_hold  <= core_hold_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: drives byte streams with stalls and checks
// each write against words assembled from the stimulus bytes.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len_words;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             error;
    logic             core_hold;

    int n_cmp   = 0;
    int n_err   = 0;
    int wr_seen = 0;
    int wr_exp  = 0;
    logic [7:0] stim[$];

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LEN_W      (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_words(len_words),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .core_hold(core_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 0);
        check_eq({tag, "_we"},    32'(mem_we), 0);
        check_eq({tag, "_addr"},  mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_err"},   32'(error), 0);
        check_eq({tag, "_hold"},  32'(core_hold), 1);
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    // Quiet cycles with junk on the byte input, which must never be taken
    task automatic idle_cycles(input int n, input bit exp_done, input bit exp_hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(in_ready), 0);
            check_eq("idle_we",    32'(mem_we), 0);
            check_eq("idle_busy",  32'(busy), 0);
            check_eq("idle_done",  32'(done), 32'(exp_done));
            check_eq("idle_hold",  32'(core_hold), 32'(exp_hold));
            start    = 1'b0;
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
        end
    endtask

    task automatic bad_start(input int len, input bit exp_err);
        @(negedge clk);
        start     = 1'b1;
        len_words = LEN_W'(len);
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        check_eq("bad_done",  32'(done), 1);
        check_eq("bad_err",   32'(error), 32'(exp_err));
        check_eq("bad_hold",  32'(core_hold), 32'(exp_err));
        check_eq("bad_ready", 32'(in_ready), 0);
        check_eq("bad_we",    32'(mem_we), 0);
        idle_cycles(3, 1'b1, exp_err);
    endtask

    // Load len words from stim; optional fixed gap before each byte, random stalls,
    // an ignored start pulse mid-load, or an async reset after abort_at accepted bytes.
    task automatic load(input int len, input int gap, input int stall_pct,
                        input bit poke, input int abort_at);
        int nacc = 0;
        int w = 0;
        int cyc = 0;
        int idle_left;
        int total;
        int budget;
        bit wr_pending = 1'b0;
        total     = 4 * len;
        budget    = len * 4 * (gap + 12) + 20;
        idle_left = gap;
        @(negedge clk);
        start     = 1'b1;
        len_words = LEN_W'(len);
        in_valid  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        len_words = LEN_W'($urandom);
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_hold", 32'(core_hold), 1);
        check_eq("start_done", 32'(done), 0);
        check_eq("start_err",  32'(error), 0);
        while (1'b1) begin
            if (abort_at > 0 && nacc == abort_at) begin
                #2 rst = 1'b0;
                #1 check_reset_vals("abort");
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (wr_pending) begin
                check_eq("wr_we",    32'(mem_we), 1);
                check_eq("wr_ready", 32'(in_ready), 0);
                check_eq("wr_addr",  mem_addr, BASE + 32'(w * 4));
                check_eq("wr_data",  mem_wdata,
                         {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
                w++;
                wr_exp++;
                wr_pending = 1'b0;
            end else begin
                check_eq("recv_we",    32'(mem_we), 0);
                check_eq("recv_ready", 32'(in_ready), 1);
            end
            if (w == len) begin
                in_valid = 1'b0;
                break;
            end
            start = poke && (cyc == 2);
            if (start) len_words = LEN_W'($urandom);
            if (!in_ready) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end else if (nacc < total && idle_left == 0 &&
                         $urandom_range(99) >= stall_pct) begin
                in_valid  = 1'b1;
                in_data   = stim[nacc];
                nacc++;
                idle_left = gap;
                if (nacc % 4 == 0) wr_pending = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                if (idle_left > 0) idle_left--;
            end
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                check_eq("load_timeout", 32'(w), 32'(len));
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("fin_done",  32'(done), 1);
        check_eq("fin_err",   32'(error), 0);
        check_eq("fin_hold",  32'(core_hold), 0);
        check_eq("fin_busy",  32'(busy), 0);
        check_eq("fin_ready", 32'(in_ready), 0);
        check_eq("fin_we",    32'(mem_we), 0);
        check_eq("fin_addr",  mem_addr, BASE + 32'((len - 1) * 4));
        check_eq("fin_wdata", mem_wdata,
                 {stim[4*len-1], stim[4*len-2], stim[4*len-3], stim[4*len-4]});
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        idle_cycles(10, 1'b0, 1'b1);

        stim = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        load(2, 0, 0, 1'b0, 0);

        stim = '{8'he3, 8'h0c, 8'h00, 8'hfe};
        load(1, 3, 0, 1'b0, 0);

        bad_start(DEPTH + 1, 1'b1);
        bad_start(0, 1'b0);

        fill_random(4 * DEPTH);
        load(DEPTH, 0, 0, 1'b0, 0);

        fill_random(12);
        load(3, 0, 0, 1'b0, 6);
        idle_cycles(10, 1'b0, 1'b1);

        fill_random(4);
        load(1, 0, 20, 1'b0, 0);
        fill_random(8);
        load(2, 0, 20, 1'b1, 0);
        bad_start(DEPTH + 1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            int len;
            len = $urandom_range(6, 1);
            fill_random(4 * len);
            load(len, $urandom_range(2, 0), 30, 1'($urandom), 0);
        end

        repeat (3) @(negedge clk);
        check_eq("write_count", 32'(wr_seen), 32'(wr_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the core's word-organised, byte-addressed instruction memory.
- Accepts a byte stream (valid/ready), assembles little-endian 32-bit instruction words and issues one memory write per word.
- Holds the core in reset until a load completes successfully.
- Sits between the host/debug byte source and the instruction memory write port.

Parameters:
DEPTH_WORDS, 1024, instruction memory depth in 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of the first word written (word-aligned)
LEN_W, 11, width of len_words (must hold DEPTH_WORDS)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  load request, sampled in IDLE or DONE only
len_words  input  LEN_W  number of words to load, sampled with start
in_valid  input  1  byte source has data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction memory write strobe
mem_addr  output  32  byte address of write (word-aligned)
mem_wdata  output  32  word to write
busy  output  1  load in progress
done  output  1  last load finished (sticky until next accepted start)
error  output  1  last start had len_words > DEPTH_WORDS
core_hold  output  1  keep core in reset

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, core_hold=1.
  - byte_idx=0, word_idx=0.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE / DONE:
  - On start with len_words > DEPTH_WORDS: error=1, done=1, state goes to (or stays in) DONE, no writes.
  - On start with len_words == 0: done=1, error=0, go to DONE, no writes.
  - On any other start: clear done/error, latch length, word_idx=0, byte_idx=0, go to RECV next cycle.
- RECV:
  - in_ready=1 combinationally; a byte is accepted when in_valid && in_ready.
  - Byte k (k = byte_idx, 0..3) is stored into assembly bits [8k+7:8k], so the first byte lands in the LSB.
  - byte_idx increments on each accepted byte.
  - On the 4th accepted byte, go to WRITE.
  - No byte is consumed when in_valid=0; the stream may stall indefinitely.
- WRITE (exactly one cycle):
  - mem_we=1, in_ready=0.
  - mem_addr = BASE_ADDR + (word_idx << 2); mem_wdata = assembled word.
  - Next state: if word_idx == len-1, go to DONE with done=1; else word_idx++, byte_idx=0, go to RECV.
- mem_addr and mem_wdata are registered: valid in the WRITE cycle and hold their last value afterwards. mem_we is high only in WRITE.
- Latency and throughput:
  - Write occurs 1 cycle after the 4th byte is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
  - A start accepted at cycle t gives in_ready=1 at cycle t+1.
- Status outputs:
  - busy=1 in RECV and WRITE.
  - core_hold=0 only in DONE with error=0; asserted from the cycle start is accepted.
- start while busy is ignored; len_words is ignored except on an accepted start.
- Address wrap: not possible, because len is bounded by DEPTH_WORDS; last address = BASE_ADDR + 4*(len-1).
- Reset mid-load: immediate return to reset values. Words already written remain in memory. A partial assembly word is discarded and never written.
- in_data is ignored whenever in_ready=0.

Test Plan:
- Reset then idle: rst low then high, no start -> core_hold=1, in_ready=0, mem_we=0, done=0 indefinitely.
- Basic load: start, len_words=2, bytes 93 80 10 00 93 80 10 00 with in_valid held high -> mem_we pulses twice:
  - addr 0x0, data 0x00108093;
  - addr 0x4, data 0x00108093;
  - then done=1 and core_hold=0 in the cycle after the second write.
- Stalled stream: len=1, bytes e3 0c 00 fe with in_valid low for 3 cycles between bytes -> single write of 0xfe000ce3 at addr 0x0; no extra accepts; in_ready high throughout RECV.
- Bounds:
  - len_words=1025 -> error=1, done=1, core_hold=1, no mem_we.
  - len_words=0 -> done=1, error=0, core_hold=0, no mem_we.
- Reset mid-load: len=3; assert rst after word 0 is written plus 2 bytes of word 1 -> all outputs at reset values; no write to addr 0x4 occurs.
- Restart and ignored start: after DONE, start with len=1 -> core_hold rises, done clears, new word written at BASE_ADDR. A start pulsed during RECV is ignored (word count unchanged).
